// File: rtl/sdr_pkg.sv
// Shared SDRAM definitions for the initialisation sequencer and the
// write/read controllers: command encodings {nRAS,nCAS,nWE}, mode-register
// field values, the A10 all-banks address and the init FSM state type.
package sdr_pkg;

    localparam int STATE_W = 4;
    localparam int CMD_W   = 3;
    localparam int DLY_W   = 16;
    localparam int REF_W   = 4;

    // {nRAS, nCAS, nWE}
    localparam logic [CMD_W-1:0] CMD_NOP       = 3'b111;
    localparam logic [CMD_W-1:0] CMD_ACTIVE    = 3'b011;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 3'b100;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE = 3'b010;
    localparam logic [CMD_W-1:0] CMD_REFRESH   = 3'b001;
    localparam logic [CMD_W-1:0] CMD_LOAD_MODE = 3'b000;

    // A10 high during PRECHARGE selects all banks
    localparam logic [12:0] A10_ALL_BANKS = 13'h400;

    // Mode-register fields
    localparam logic [2:0] MR_BL_1      = 3'b000;
    localparam logic       MR_BT_SEQ    = 1'b0;
    localparam logic [2:0] MR_CL_3      = 3'b011;
    localparam logic       MR_WB_BURST  = 1'b0;

    // Pack mode-register fields into the A[12:0] layout
    function automatic logic [12:0] mode_reg_pack(input logic wb, input logic [2:0] cl,
                                                  input logic bt, input logic [2:0] bl);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

    localparam logic [12:0] MODE_REG_DEFAULT = mode_reg_pack(MR_WB_BURST, MR_CL_3, MR_BT_SEQ, MR_BL_1);

    // Width 4 leaves encodings 8..15 unused; they recover to S_WAIT
    typedef enum logic [STATE_W-1:0] {
        S_WAIT = 4'd0,
        S_PRE  = 4'd1,
        S_TRP  = 4'd2,
        S_REF  = 4'd3,
        S_TRFC = 4'd4,
        S_MRS  = 4'd5,
        S_TMRD = 4'd6,
        S_DONE = 4'd7
    } state_e;

endpackage

// File: rtl/sdr_init_if.sv
// SDRAM command bus plus init_done status.
// master: driven by the init sequencer; slave: observed by muxing/consumers.
interface sdr_init_if;
    logic        sdr_CKE;
    logic        sdr_nCS;
    logic        sdr_nRAS;
    logic        sdr_nCAS;
    logic        sdr_nWE;
    logic [1:0]  sdr_BA;
    logic [12:0] sdr_A;
    logic        init_done;

    modport master (output sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, init_done);
    modport slave  (input  sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A, init_done);
endinterface

// File: rtl/sdr_delay_cnt.sv
// Loadable down-counter with a registered one-cycle expire pulse.
// Ports: clk, rst (async, active-high), load_i/val_i (load count),
//        expire_o (high for one cycle once the count has reached zero).
// A load of N makes expire_o high in the cycle that follows N further edges,
// so a load of 0 expires immediately after the loading edge.
module sdr_delay_cnt #(
    parameter int          W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic         expire_q;

    // Count down to zero, flag the arrival at zero for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= RST_VAL;
            expire_q <= (RST_VAL == ZERO);
        end else if (load_i) begin
            cnt_q    <= val_i;
            expire_q <= (val_i == ZERO);
        end else if (cnt_q != ZERO) begin
            cnt_q    <= cnt_q - ONE;
            expire_q <= (cnt_q == ONE);
        end else begin
            cnt_q    <= cnt_q;
            expire_q <= 1'b0;
        end
    end

    assign expire_o = expire_q;
endmodule

// File: rtl/sdr_init.sv
// SDRAM power-up initialisation sequencer: power-up NOP wait, PRECHARGE ALL,
// NUM_REF x AUTO REFRESH, LOAD MODE REGISTER, then sticky init_done.
// Ports: clk, rst (async, active-high), bus (sdr_init_if.master: CKE, nCS,
//        nRAS/nCAS/nWE, BA, A, init_done), all registered.
// Build option: SDR_INIT_FAST_SIM_EN shortens the power-up wait to 16 cycles.
module sdr_init
    import sdr_pkg::*;
#(
    parameter int unsigned T_POWERUP = 33400,
    parameter int unsigned T_RP      = 3,
    parameter int unsigned T_RFC     = 10,
    parameter int unsigned NUM_REF   = 2,
    parameter int unsigned T_MRD     = 2,
    parameter logic [12:0] MODE_REG  = MODE_REG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    sdr_init_if.master bus
);
`ifdef SDR_INIT_FAST_SIM_EN
    localparam int unsigned WAIT_CYC = 16;
`else
    localparam int unsigned WAIT_CYC = T_POWERUP;
`endif
    // Counter loads are one less than the spacing: the load edge is the command edge
    localparam logic [DLY_W-1:0] WAIT_LD = 16'(WAIT_CYC - 1);
    localparam logic [DLY_W-1:0] RP_LD   = 16'(T_RP - 1);
    localparam logic [DLY_W-1:0] RFC_LD  = 16'(T_RFC - 1);
    localparam logic [DLY_W-1:0] MRD_LD  = 16'(T_MRD - 1);
    localparam logic [REF_W-1:0] NREF_L  = 4'(NUM_REF);

    state_e             state_q;
    logic               cke_q;
    logic               ncs_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [1:0]         ba_q;
    logic [12:0]        a_q;
    logic               done_q;
    logic [REF_W-1:0]   ref_cnt_q;
    logic               expire_s;
    logic               cnt_load_d;
    logic [DLY_W-1:0]   cnt_val_d;

    // Reset value preloads the power-up wait so no extra entry cycle is spent
    sdr_delay_cnt #(.W(DLY_W), .RST_VAL(WAIT_LD)) u_dly (
        .clk      (clk),
        .rst      (rst),
        .load_i   (cnt_load_d),
        .val_i    (cnt_val_d),
        .expire_o (expire_s)
    );

    // Reload the delay counter on each command edge with the spacing to the next step
    always_comb begin
        cnt_load_d = 1'b0;
        cnt_val_d  = 16'd0;
        case (state_q)
            S_WAIT: begin
                cnt_load_d = expire_s;
                cnt_val_d  = RP_LD;
            end
            S_PRE, S_TRP: begin
                cnt_load_d = expire_s;
                cnt_val_d  = RFC_LD;
            end
            S_REF, S_TRFC: begin
                cnt_load_d = expire_s;
                if (ref_cnt_q < NREF_L) begin
                    cnt_val_d = RFC_LD;
                end else begin
                    cnt_val_d = MRD_LD;
                end
            end
            S_MRS, S_TMRD: begin
                cnt_load_d = 1'b0;
                cnt_val_d  = 16'd0;
            end
            S_DONE: begin
                cnt_load_d = 1'b0;
                cnt_val_d  = 16'd0;
            end
            default: begin
                cnt_load_d = 1'b1;
                cnt_val_d  = WAIT_LD;
            end
        endcase
    end

    // Sequencer FSM; command states also test expiry so a spacing of 1 is exact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_WAIT;
            cke_q     <= 1'b0;
            ncs_q     <= 1'b1;
            cmd_q     <= CMD_NOP;
            ba_q      <= 2'b00;
            a_q       <= 13'h0000;
            done_q    <= 1'b0;
            ref_cnt_q <= 4'd0;
        end else begin
            cke_q <= 1'b1;
            ncs_q <= 1'b0;
            cmd_q <= CMD_NOP;
            ba_q  <= 2'b00;
            a_q   <= 13'h0000;
            case (state_q)
                S_WAIT: begin
                    if (expire_s) begin
                        cmd_q   <= CMD_PRECHARGE;
                        a_q     <= A10_ALL_BANKS;
                        state_q <= S_PRE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_PRE, S_TRP: begin
                    if (expire_s) begin
                        cmd_q     <= CMD_REFRESH;
                        ref_cnt_q <= 4'd1;
                        state_q   <= S_REF;
                    end else begin
                        state_q <= S_TRP;
                    end
                end
                S_REF, S_TRFC: begin
                    if (expire_s && (ref_cnt_q < NREF_L)) begin
                        cmd_q     <= CMD_REFRESH;
                        ref_cnt_q <= ref_cnt_q + 4'd1;
                        state_q   <= S_REF;
                    end else if (expire_s) begin
                        cmd_q   <= CMD_LOAD_MODE;
                        a_q     <= MODE_REG;
                        state_q <= S_MRS;
                    end else begin
                        state_q <= S_TRFC;
                    end
                end
                S_MRS, S_TMRD: begin
                    if (expire_s) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_TMRD;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    // Corrupted encoding: restart the wait, bus stays NOP
                    ref_cnt_q <= 4'd0;
                    state_q   <= S_WAIT;
                end
            endcase
        end
    end

    assign bus.sdr_CKE   = cke_q;
    assign bus.sdr_nCS   = ncs_q;
    assign bus.sdr_nRAS  = cmd_q[2];
    assign bus.sdr_nCAS  = cmd_q[1];
    assign bus.sdr_nWE   = cmd_q[0];
    assign bus.sdr_BA    = ba_q;
    assign bus.sdr_A     = a_q;
    assign bus.init_done = done_q;
endmodule

// File: tb/tb_sdr_init.sv
module tb_sdr_init;
    import sdr_pkg::*;

    localparam int A_PWR = 24, A_RP = 3, A_RFC = 7, A_NREF = 4, A_MRD = 2;
`ifdef SDR_INIT_FAST_SIM_EN
    localparam int A_W = 16;
    localparam int D_W = 16;
    localparam int DONE_A = 49;
    int ev_exp [6] = '{16, 19, 26, 33, 40, 47};
`else
    localparam int A_W = 24;
    localparam int D_W = 33400;
    localparam int DONE_A = 57;
    int ev_exp [6] = '{24, 27, 34, 41, 48, 55};
`endif
    logic [2:0] cmd_exp [6] = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};

    typedef struct packed {
        logic        cke;
        logic        ncs;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a, rst_d;
    always #5 clk = ~clk;

    sdr_init_if bus_a();
    sdr_init_if bus_d();

    sdr_init #(.T_POWERUP(A_PWR), .T_RP(A_RP), .T_RFC(A_RFC), .NUM_REF(A_NREF),
               .T_MRD(A_MRD), .MODE_REG(13'h030))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    sdr_init dut_d (.clk(clk), .rst(rst_d), .bus(bus_d.master));

    obs_t act_a, act_d;
    assign act_a = {bus_a.sdr_CKE, bus_a.sdr_nCS, bus_a.sdr_nRAS, bus_a.sdr_nCAS, bus_a.sdr_nWE,
                    bus_a.sdr_BA, bus_a.sdr_A, bus_a.init_done};
    assign act_d = {bus_d.sdr_CKE, bus_d.sdr_nCS, bus_d.sdr_nRAS, bus_d.sdr_nCAS, bus_d.sdr_nWE,
                    bus_d.sdr_BA, bus_d.sdr_A, bus_d.init_done};

    int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
    int k_a = 0, k_d = 0;
    bit chk_a_en = 1'b1;

    // Edges since reset release (0 while reset is held)
    always @(posedge clk or posedge rst_a) if (rst_a) k_a <= 0; else k_a <= k_a + 1;
    always @(posedge clk or posedge rst_d) if (rst_d) k_d <= 0; else k_d <= k_d + 1;

    // Expected bus after k edges: commands placed on an arithmetic schedule
    function automatic obs_t model(int k, int w, int rp, int rfc, int nref, int mrd, logic [12:0] mr);
        obs_t o;
        int   mrs;
        o = '{cke: 1'b0, ncs: 1'b1, cmd: 3'b111, ba: 2'b00, a: 13'h0, done: 1'b0};
        mrs = w + rp + nref * rfc;
        if (k >= 1) begin
            o.cke = 1'b1;
            o.ncs = 1'b0;
        end
        if (k >= 1 && k == w) begin
            o.cmd = 3'b010; o.a = 13'h400;
        end else if (k >= w + rp && k < mrs && ((k - w - rp) % rfc) == 0) begin
            o.cmd = 3'b001;
        end else if (k >= 1 && k == mrs) begin
            o.cmd = 3'b000; o.a = mr;
        end
        if (k >= 1 && k >= mrs + mrd) o.done = 1'b1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else begin
            fail_cnt++;
            if (fail_cnt <= 50)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare of both instances against the schedule model
    always @(negedge clk) begin
        if (chk_a_en) chk("cyc_a", {11'b0, act_a}, {11'b0, model(k_a, A_W, A_RP, A_RFC, A_NREF, A_MRD, 13'h030)});
        chk("cyc_d", {11'b0, act_d}, {11'b0, model(k_d, D_W, 3, 10, 2, 2, 13'h030)});
    end

    // Command monitor for the default-parameter instance
    logic [2:0] d_seq[$];
    int d_pre_edge = -1;
    always @(negedge clk) begin
        if (!rst_d && act_d.cmd != 3'b111) begin
            d_seq.push_back(act_d.cmd);
            if (act_d.cmd == 3'b010) d_pre_edge = k_d;
        end
    end

    int   ev_k[$];
    obs_t ev_o[$];
    int   done_k;

    task automatic capture(input int ncyc);
        ev_k.delete(); ev_o.delete(); done_k = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (act_a.cmd != 3'b111) begin ev_k.push_back(k_a); ev_o.push_back(act_a); end
            if (act_a.done && done_k < 0) done_k = k_a;
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_d = 1'b0;
        #1; rst_a = 1'b1; rst_d = 1'b1;
        @(negedge clk);
        chk("rst_val_a", {11'b0, act_a}, {11'b0, 1'b0, 1'b1, 3'b111, 2'b00, 13'h0, 1'b0});
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_d = 1'b0;

        // Phase 1: full sequence with explicit edge numbers
        @(negedge clk);
        chk("edge1_cke", act_a.cke, 1);
        chk("edge1_ncs", act_a.ncs, 0);
        capture(A_W + 60);
        chk("p1_count", ev_k.size(), 6);
        for (int i = 0; i < 6 && i < ev_k.size(); i++) begin
            chk($sformatf("p1_edge%0d", i), ev_k[i], ev_exp[i]);
            chk($sformatf("p1_cmd%0d", i), ev_o[i].cmd, cmd_exp[i]);
        end
        if (ev_o.size() == 6) begin
            chk("p1_pre_a", ev_o[0].a, 32'h400);
            chk("p1_mrs_a", ev_o[5].a, 32'h030);
            chk("p1_mrs_ba", ev_o[5].ba, 0);
        end
        chk("p1_done_edge", done_k, DONE_A);

        // Phase 2: reset at edge 25 for 3 cycles, then full restart
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        repeat (24) @(negedge clk);
        @(posedge clk); #2; rst_a = 1'b1; #1;
        chk("async_rst", {11'b0, act_a}, {11'b0, 1'b0, 1'b1, 3'b111, 2'b00, 13'h0, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk); rst_a = 1'b0;
        capture(A_W + 10);
        if (ev_k.size() > 0) chk("p2_pre_edge", ev_k[0], A_W);
        else chk("p2_pre_seen", 0, 1);

        // Phase 3: random run lengths, reset offsets and hold times
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(A_W + 45, 1)) @(negedge clk);
            @(posedge clk); #($urandom_range(4, 1)); rst_a = 1'b1;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            @(negedge clk); rst_a = 1'b0;
        end

        // Phase 4: run past init_done, then hold 1000 cycles
        repeat (A_W + 60 + 1000) @(negedge clk);
        chk("hold_done", act_a.done, 1);
        chk("hold_nop", act_a.cmd, 3'b111);
        chk("hold_a0", act_a.a, 0);

        // Phase 5: corrupt the state register, expect recovery to S_WAIT with NOP
        chk_a_en = 1'b0;
        @(negedge clk);
        force dut_a.state_q = state_e'(4'hF);
        #1; release dut_a.state_q;
        @(posedge clk); #1;
        chk("illegal_state", dut_a.state_q, S_WAIT);
        chk("illegal_nop", act_a.cmd, 3'b111);
        chk("illegal_a0", act_a.a, 0);

        // Default instance: let its full sequence finish, then audit the command log
        while (k_d < D_W + 40) @(negedge clk);
        chk("d_count", d_seq.size(), 4);
        if (d_seq.size() == 4) begin
            chk("d_seq0", d_seq[0], 3'b010);
            chk("d_seq1", d_seq[1], 3'b001);
            chk("d_seq2", d_seq[2], 3'b001);
            chk("d_seq3", d_seq[3], 3'b000);
        end
        chk("d_pre_edge", d_pre_edge, D_W);
        chk("d_done", act_d.done, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
